frame_phase_scheduler: RTL and testbench

FRAME_PHASE_SCHEDULER -- requirements
Module: frame_phase_scheduler

---
 rtl/bram_pkg.sv | 24 ++
 rtl/rr_arbiter2.sv | 39 +++
 rtl/frame_phase_scheduler.sv | 165 ++++++++++++++++
 tb/tb_frame_phase_scheduler.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// Shared phase encodings and sizing helper for the frame buffer scheduler.
package bram_pkg;

  // Buffer ownership phases; 2'b00 is unused and falls back to PhLoad.
  typedef enum logic [1:0] {
    PhLoad    = 2'b01,
    PhProcess = 2'b10,
    PhGet     = 2'b11
  } phase_e;

  // Number of bits needed to hold 'value' (at least 1).
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned bits;
    bits = 0;
    for (int unsigned v = value; v > 0; v = v >> 1) begin
      bits++;
    end
    if (bits == 0) begin
      bits = 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: a lone requester wins, on conflict the side not granted last wins.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // High when req[1] was the most recent winner, so req[0] wins the next conflict.
  logic last_q;
  logic last_d;

  // Grant selection and last-winner tracking.
  always_comb begin
    gnt    = 2'b00;
    last_d = last_q;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    if (gnt[0]) begin
      last_d = 1'b0;
    end else if (gnt[1]) begin
      last_d = 1'b1;
    end
  end

  // Last-grant register; reset favours req[0].
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/frame_phase_scheduler.sv
// Time-shares one single-port frame RAM between pixel load, optional in-place processing
// (convolver reads / writebacks) and host readout, one phase at a time.
module frame_phase_scheduler
  import bram_pkg::*;
#(
  parameter int unsigned RAM_WIDTH    = 8,
  parameter int unsigned RAM_DEPTH    = 65536,
  parameter int unsigned IMAGE_WIDTH  = 10,
  parameter int unsigned IMAGE_HEIGHT = 10,
  parameter int unsigned TO_PROCESS   = 0,
  localparam int unsigned ADDR_W      = clogb2(RAM_DEPTH - 1),
  localparam int unsigned RESOLUTION  = IMAGE_WIDTH * IMAGE_HEIGHT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_ld_valid,
  input  logic [RAM_WIDTH-1:0] i_ld_data,
  output logic                 o_ld_ready,
  input  logic                 i_cv_req,
  input  logic [ADDR_W-1:0]    i_cv_addr,
  output logic                 o_cv_gnt,
  output logic                 o_cv_rvalid,
  output logic [RAM_WIDTH-1:0] o_cv_rdata,
  input  logic                 i_wb_req,
  input  logic [ADDR_W-1:0]    i_wb_addr,
  input  logic [RAM_WIDTH-1:0] i_wb_data,
  output logic                 o_wb_gnt,
  input  logic                 i_cv_done,
  input  logic                 i_gt_req,
  output logic                 o_gt_rvalid,
  output logic [RAM_WIDTH-1:0] o_gt_rdata,
  output logic                 o_ram_en,
  output logic                 o_ram_we,
  output logic [ADDR_W-1:0]    o_ram_addr,
  output logic [RAM_WIDTH-1:0] o_ram_wdata,
  input  logic [RAM_WIDTH-1:0] i_ram_rdata,
  output logic [1:0]           o_phase,
  output logic                 o_frame_done
);

  if (RESOLUTION > RAM_DEPTH) begin : g_res_check
    $error("frame_phase_scheduler: IMAGE_WIDTH*IMAGE_HEIGHT exceeds RAM_DEPTH");
  end

  // One extra bit so a frame filling the whole address space still compares correctly.
  localparam logic [ADDR_W:0]   ResLimit = (ADDR_W + 1)'(RESOLUTION);
  localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(RESOLUTION - 1);

  phase_e            phase_q, phase_d;
  logic [ADDR_W-1:0] ld_ptr_q, ld_ptr_d;
  logic [ADDR_W-1:0] gt_ptr_q, gt_ptr_d;
  logic              cv_rvalid_q, cv_pad_q;
  logic              gt_rvalid_q, frame_done_q;
  logic              gt_read, frame_end;
  logic              proc_active;
  logic              cv_in_range, wb_in_range;
  logic [1:0]        arb_req, arb_gnt;

  assign cv_in_range = ({1'b0, i_cv_addr} < ResLimit);
  assign wb_in_range = ({1'b0, i_wb_addr} < ResLimit);

  // Only the PROCESS phase lets the convolver and writeback ports compete.
  assign proc_active = (phase_q == PhProcess) && !reset;
  assign arb_req     = {i_wb_req & proc_active, i_cv_req & proc_active};

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (arb_req),
    .gnt   (arb_gnt)
  );

  // Phase sequencing, pointer advance and the single RAM access of this cycle.
  always_comb begin
    phase_d     = phase_q;
    ld_ptr_d    = ld_ptr_q;
    gt_ptr_d    = gt_ptr_q;
    gt_read     = 1'b0;
    frame_end   = 1'b0;
    o_ram_en    = 1'b0;
    o_ram_we    = 1'b0;
    o_ram_addr  = '0;
    o_ram_wdata = '0;
    if (!reset) begin
      case (phase_q)
        PhLoad: begin
          if (i_ld_valid) begin
            o_ram_en    = 1'b1;
            o_ram_we    = 1'b1;
            o_ram_addr  = ld_ptr_q;
            o_ram_wdata = i_ld_data;
            if (ld_ptr_q == LastIdx) begin
              ld_ptr_d = '0;
              phase_d  = (TO_PROCESS != 0) ? PhProcess : PhGet;
            end else begin
              ld_ptr_d = ld_ptr_q + 1'b1;
            end
          end
        end
        PhProcess: begin
          // Out-of-frame accesses are granted but never touch the RAM.
          if (arb_gnt[0] && cv_in_range) begin
            o_ram_en   = 1'b1;
            o_ram_addr = i_cv_addr;
          end else if (arb_gnt[1] && wb_in_range) begin
            o_ram_en    = 1'b1;
            o_ram_we    = 1'b1;
            o_ram_addr  = i_wb_addr;
            o_ram_wdata = i_wb_data;
          end
          if (i_cv_done) begin
            phase_d = PhGet;
          end
        end
        PhGet: begin
          if (i_gt_req) begin
            o_ram_en   = 1'b1;
            o_ram_addr = gt_ptr_q;
            gt_read    = 1'b1;
            if (gt_ptr_q == LastIdx) begin
              gt_ptr_d  = '0;
              phase_d   = PhLoad;
              frame_end = 1'b1;
            end else begin
              gt_ptr_d = gt_ptr_q + 1'b1;
            end
          end
        end
        default: phase_d = PhLoad;
      endcase
    end
  end

  // State registers; reset aborts the frame and drops any read still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q      <= PhLoad;
      ld_ptr_q     <= '0;
      gt_ptr_q     <= '0;
      cv_rvalid_q  <= 1'b0;
      cv_pad_q     <= 1'b0;
      gt_rvalid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      ld_ptr_q     <= ld_ptr_d;
      gt_ptr_q     <= gt_ptr_d;
      cv_rvalid_q  <= arb_gnt[0];
      cv_pad_q     <= arb_gnt[0] & ~cv_in_range;
      gt_rvalid_q  <= gt_read;
      frame_done_q <= frame_end;
    end
  end

  assign o_ld_ready   = (phase_q == PhLoad);
  assign o_phase      = phase_q;
  assign o_cv_gnt     = arb_gnt[0];
  assign o_wb_gnt     = arb_gnt[1];
  assign o_cv_rvalid  = cv_rvalid_q;
  assign o_cv_rdata   = (cv_rvalid_q && !cv_pad_q) ? i_ram_rdata : '0;
  assign o_gt_rvalid  = gt_rvalid_q;
  assign o_gt_rdata   = gt_rvalid_q ? i_ram_rdata : '0;
  assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_frame_phase_scheduler.sv
// Bench: dut_a runs LOAD->GET, dut_b runs LOAD->PROCESS->GET; both share stimulus and each
// has its own behavioural RAM. Expected data comes from arrays kept by the bench.
module tb_frame_phase_scheduler;

  localparam int unsigned Res = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_data = '0;
  logic        cv_req = 1'b0;
  logic [15:0] cv_addr = '0;
  logic        wb_req = 1'b0;
  logic [15:0] wb_addr = '0;
  logic [7:0]  wb_data = '0;
  logic        cv_done = 1'b0;
  logic        gt_req = 1'b0;

  logic        a_ld_ready, a_cv_gnt, a_cv_rvalid, a_wb_gnt, a_gt_rvalid, a_ram_en, a_ram_we;
  logic        a_frame_done;
  logic [7:0]  a_cv_rdata, a_gt_rdata, a_ram_wdata, a_ram_rdata;
  logic [15:0] a_ram_addr;
  logic [1:0]  a_phase;
  logic        b_ld_ready, b_cv_gnt, b_cv_rvalid, b_wb_gnt, b_gt_rvalid, b_ram_en, b_ram_we;
  logic        b_frame_done;
  logic [7:0]  b_cv_rdata, b_gt_rdata, b_ram_wdata, b_ram_rdata;
  logic [15:0] b_ram_addr;
  logic [1:0]  b_phase;

  logic [7:0]  mem_a [0:65535];
  logic [7:0]  mem_b [0:65535];
  logic [7:0]  exp_a [0:Res-1];
  logic [7:0]  exp_b [0:Res-1];
  bit          cv_turn = 1'b1;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  frame_phase_scheduler #(.TO_PROCESS(0)) dut_a (
    .clk(clk), .reset(reset), .i_ld_valid(ld_valid), .i_ld_data(ld_data),
    .o_ld_ready(a_ld_ready), .i_cv_req(cv_req), .i_cv_addr(cv_addr), .o_cv_gnt(a_cv_gnt),
    .o_cv_rvalid(a_cv_rvalid), .o_cv_rdata(a_cv_rdata), .i_wb_req(wb_req),
    .i_wb_addr(wb_addr), .i_wb_data(wb_data), .o_wb_gnt(a_wb_gnt), .i_cv_done(cv_done),
    .i_gt_req(gt_req), .o_gt_rvalid(a_gt_rvalid), .o_gt_rdata(a_gt_rdata),
    .o_ram_en(a_ram_en), .o_ram_we(a_ram_we), .o_ram_addr(a_ram_addr),
    .o_ram_wdata(a_ram_wdata), .i_ram_rdata(a_ram_rdata), .o_phase(a_phase),
    .o_frame_done(a_frame_done)
  );

  frame_phase_scheduler #(.TO_PROCESS(1)) dut_b (
    .clk(clk), .reset(reset), .i_ld_valid(ld_valid), .i_ld_data(ld_data),
    .o_ld_ready(b_ld_ready), .i_cv_req(cv_req), .i_cv_addr(cv_addr), .o_cv_gnt(b_cv_gnt),
    .o_cv_rvalid(b_cv_rvalid), .o_cv_rdata(b_cv_rdata), .i_wb_req(wb_req),
    .i_wb_addr(wb_addr), .i_wb_data(wb_data), .o_wb_gnt(b_wb_gnt), .i_cv_done(cv_done),
    .i_gt_req(gt_req), .o_gt_rvalid(b_gt_rvalid), .o_gt_rdata(b_gt_rdata),
    .o_ram_en(b_ram_en), .o_ram_we(b_ram_we), .o_ram_addr(b_ram_addr),
    .o_ram_wdata(b_ram_wdata), .i_ram_rdata(b_ram_rdata), .o_phase(b_phase),
    .o_frame_done(b_frame_done)
  );

  always @(posedge clk) begin
    if (a_ram_en) begin
      if (a_ram_we) mem_a[a_ram_addr] <= a_ram_wdata;
      else          a_ram_rdata <= mem_a[a_ram_addr];
    end
    if (b_ram_en) begin
      if (b_ram_we) mem_b[b_ram_addr] <= b_ram_wdata;
      else          b_ram_rdata <= mem_b[b_ram_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ld_valid = 0; cv_req = 0; wb_req = 0; cv_done = 0; gt_req = 0;
  endtask

  task automatic test_reset();
    reset = 1; ld_valid = 1; gt_req = 1; cv_req = 1; wb_req = 1; cv_addr = 3; wb_addr = 4;
    cv_turn = 1;
    tick(); #4;
    n_checks++; if ({a_cv_gnt, a_wb_gnt, a_ram_en} !== 3'b000)
      $display("FAIL reset_strobes_a got %b want 000", {a_cv_gnt, a_wb_gnt, a_ram_en}); else n_pass++;
    n_checks++; if ({b_cv_gnt, b_wb_gnt, b_ram_en} !== 3'b000)
      $display("FAIL reset_strobes_b got %b want 000", {b_cv_gnt, b_wb_gnt, b_ram_en}); else n_pass++;
    tick();
    n_checks++; if ({a_phase, a_ld_ready, a_cv_rvalid, a_gt_rvalid, a_frame_done, a_cv_rdata, a_gt_rdata}
                    !== {2'b01, 1'b1, 3'b000, 16'h0})
      $display("FAIL reset_state_a got %b %b %b%b%b", a_phase, a_ld_ready, a_cv_rvalid, a_gt_rvalid,
               a_frame_done); else n_pass++;
    n_checks++; if ({b_phase, b_ld_ready, b_cv_rvalid, b_gt_rvalid, b_frame_done, b_cv_rdata, b_gt_rdata}
                    !== {2'b01, 1'b1, 3'b000, 16'h0})
      $display("FAIL reset_state_b got %b %b %b%b%b", b_phase, b_ld_ready, b_cv_rvalid, b_gt_rvalid,
               b_frame_done); else n_pass++;
    reset = 0;
    idle();
  endtask

  task automatic test_ignore_in_load();
    for (int k = 0; k < 4; k++) begin
      gt_req = 1; cv_req = 1; wb_req = 1;
      cv_addr = 16'($urandom_range(0, Res - 1)); wb_addr = 16'($urandom_range(0, Res - 1));
      #4;
      n_checks++; if ({a_cv_gnt, a_wb_gnt, a_ram_en, a_ld_ready, b_cv_gnt, b_wb_gnt, b_ram_en, b_ld_ready}
                      !== 8'b0001_0001)
        $display("FAIL ignore_in_load got %b %b want 0001 0001",
                 {a_cv_gnt, a_wb_gnt, a_ram_en, a_ld_ready}, {b_cv_gnt, b_wb_gnt, b_ram_en, b_ld_ready});
      else n_pass++;
      tick();
      n_checks++; if ({a_cv_rvalid, a_gt_rvalid, b_cv_rvalid, b_gt_rvalid} !== 4'b0000)
        $display("FAIL ignore_rvalid got %b want 0000",
                 {a_cv_rvalid, a_gt_rvalid, b_cv_rvalid, b_gt_rvalid}); else n_pass++;
    end
    idle();
  endtask

  task automatic test_reset_midload();
    for (int i = 0; i < 50; i++) begin
      ld_valid = 1; ld_data = 8'($urandom);
      #4;
      n_checks++; if ({a_ram_en, a_ram_we, a_ram_addr, b_ram_en, b_ram_we, b_ram_addr}
                      !== {2'b11, 16'(i), 2'b11, 16'(i)})
        $display("FAIL midload_addr got %0d/%0d want %0d", a_ram_addr, b_ram_addr, i); else n_pass++;
      tick();
    end
    ld_valid = 0; reset = 1; cv_turn = 1;
    tick();
    reset = 0;
    n_checks++; if ({a_phase, a_cv_rvalid, a_gt_rvalid, b_phase, b_cv_rvalid, b_gt_rvalid}
                    !== {2'b01, 2'b00, 2'b01, 2'b00})
      $display("FAIL midload_reset got %b %b want 01 01", a_phase, b_phase); else n_pass++;
  endtask

  task automatic test_load();
    logic [7:0] d;
    for (int i = 0; i < Res; i++) begin
      d = 8'($urandom);
      ld_valid = 1; ld_data = d;
      exp_a[i] = d; exp_b[i] = d;
      #4;
      n_checks++; if ({a_phase, a_ld_ready, a_ram_en, a_ram_we, a_ram_addr, a_ram_wdata}
                      !== {2'b01, 3'b111, 16'(i), d})
        $display("FAIL load_a[%0d] got addr %0d data %h want %0d %h", i, a_ram_addr, a_ram_wdata, i, d);
      else n_pass++;
      n_checks++; if ({b_phase, b_ld_ready, b_ram_en, b_ram_we, b_ram_addr, b_ram_wdata}
                      !== {2'b01, 3'b111, 16'(i), d})
        $display("FAIL load_b[%0d] got addr %0d data %h want %0d %h", i, b_ram_addr, b_ram_wdata, i, d);
      else n_pass++;
      tick();
    end
    ld_valid = 0;
    n_checks++; if ({a_phase, a_ld_ready, b_phase, b_ld_ready} !== {2'b11, 1'b0, 2'b10, 1'b0})
      $display("FAIL load_end_phase got %b/%b want 11/10", a_phase, b_phase); else n_pass++;
  endtask

  // One PROCESS cycle on dut_b; dut_a sits in GET and must ignore cv/wb traffic.
  task automatic process_cycle(input bit c, input logic [15:0] ca, input bit w,
                               input logic [15:0] wa, input logic [7:0] wd, input bit done);
    bit eg_c, eg_w, c_in, w_in;
    logic [7:0] exp_rd;
    cv_req = c; cv_addr = ca; wb_req = w; wb_addr = wa; wb_data = wd; cv_done = done;
    c_in = (ca < 16'(Res)); w_in = (wa < 16'(Res));
    eg_c = c && (!w || cv_turn);
    eg_w = w && !eg_c;
    if (eg_c || eg_w) cv_turn = eg_w;
    exp_rd = (eg_c && c_in) ? exp_b[ca] : 8'h00;
    #4;
    n_checks++; if ({b_phase, b_cv_gnt, b_wb_gnt, b_ram_en} !== {2'b10, eg_c, eg_w, (eg_c && c_in) || (eg_w && w_in)})
      $display("FAIL proc_grant got ph %b gnt %b%b en %b want gnt %b%b", b_phase, b_cv_gnt, b_wb_gnt,
               b_ram_en, eg_c, eg_w); else n_pass++;
    if (eg_c && c_in) begin
      n_checks++; if ({b_ram_we, b_ram_addr} !== {1'b0, ca})
        $display("FAIL proc_cv_ram got we %b addr %0d want 0 %0d", b_ram_we, b_ram_addr, ca); else n_pass++;
    end
    if (eg_w && w_in) begin
      n_checks++; if ({b_ram_we, b_ram_addr, b_ram_wdata} !== {1'b1, wa, wd})
        $display("FAIL proc_wb_ram got %b %0d %h want 1 %0d %h", b_ram_we, b_ram_addr, b_ram_wdata, wa, wd);
      else n_pass++;
    end
    n_checks++; if ({a_cv_gnt, a_wb_gnt, a_ram_en} !== 3'b000)
      $display("FAIL proc_ignore_a got %b want 000", {a_cv_gnt, a_wb_gnt, a_ram_en}); else n_pass++;
    tick();
    cv_done = 0;
    n_checks++; if ({b_cv_rvalid, b_cv_rdata} !== {eg_c, exp_rd})
      $display("FAIL proc_rdata got %b %h want %b %h", b_cv_rvalid, b_cv_rdata, eg_c, exp_rd); else n_pass++;
    if (eg_w && w_in) exp_b[wa] = wd;
    if (done) begin
      n_checks++; if (b_phase !== 2'b11)
        $display("FAIL proc_done_phase got %b want 11", b_phase); else n_pass++;
    end
  endtask

  task automatic test_process();
    for (int k = 0; k < 6; k++)
      process_cycle(1, 16'($urandom_range(0, Res - 1)), 1, 16'($urandom_range(0, Res - 1)),
                    8'($urandom), 0);
    for (int k = 0; k < 3; k++)
      process_cycle(0, 16'd0, 1, 16'($urandom_range(0, Res - 1)), 8'($urandom), 0);
    process_cycle(1, 16'd100, 0, 16'd0, 8'd0, 0);
    process_cycle(1, 16'hFFFF, 0, 16'd0, 8'd0, 0);
    for (int k = 0; k < 60; k++)
      process_cycle(1'($urandom), 16'($urandom_range(0, 119)), 1'($urandom),
                    16'($urandom_range(0, 119)), 8'($urandom), 0);
    process_cycle(1, 16'($urandom_range(0, Res - 1)), 1, 16'($urandom_range(0, Res - 1)),
                  8'($urandom), 1);
    idle();
  endtask

  task automatic test_get();
    for (int i = 0; i < Res; i++) begin
      gt_req = 1;
      #4;
      n_checks++; if ({a_ram_en, a_ram_we, a_ram_addr, b_ram_en, b_ram_we, b_ram_addr}
                      !== {2'b10, 16'(i), 2'b10, 16'(i)})
        $display("FAIL get_addr got %0d/%0d want %0d", a_ram_addr, b_ram_addr, i); else n_pass++;
      tick();
      n_checks++; if ({a_gt_rvalid, a_gt_rdata, a_frame_done, a_phase}
                      !== {1'b1, exp_a[i], i == Res - 1, (i == Res - 1) ? 2'b01 : 2'b11})
        $display("FAIL get_a[%0d] got v%b %h fd%b ph%b want %h", i, a_gt_rvalid, a_gt_rdata,
                 a_frame_done, a_phase, exp_a[i]); else n_pass++;
      n_checks++; if ({b_gt_rvalid, b_gt_rdata, b_frame_done, b_phase}
                      !== {1'b1, exp_b[i], i == Res - 1, (i == Res - 1) ? 2'b01 : 2'b11})
        $display("FAIL get_b[%0d] got v%b %h fd%b ph%b want %h", i, b_gt_rvalid, b_gt_rdata,
                 b_frame_done, b_phase, exp_b[i]); else n_pass++;
    end
    gt_req = 0;
    tick();
    n_checks++; if ({a_gt_rvalid, a_frame_done, b_gt_rvalid, b_frame_done, a_gt_rdata} !== 12'h0)
      $display("FAIL get_after got %b%b%b%b %h want 0000 00", a_gt_rvalid, a_frame_done, b_gt_rvalid,
               b_frame_done, a_gt_rdata); else n_pass++;
  endtask

  task automatic test_reset_during_get();
    test_load();
    for (int k = 0; k < 3; k++) begin
      gt_req = 1;
      #4;
      n_checks++; if ({a_ram_en, a_ram_we, a_ram_addr, b_ram_en} !== {2'b10, 16'(k), 1'b0})
        $display("FAIL rget_addr got %0d en_b %b want %0d 0", a_ram_addr, b_ram_en, k); else n_pass++;
      tick();
      n_checks++; if ({a_gt_rvalid, a_gt_rdata, b_gt_rvalid} !== {1'b1, exp_a[k], 1'b0})
        $display("FAIL rget_data got %b %h want 1 %h", a_gt_rvalid, a_gt_rdata, exp_a[k]); else n_pass++;
    end
    gt_req = 1; cv_req = 1; cv_addr = 16'd7; reset = 1; cv_turn = 1;
    #4;
    n_checks++; if ({a_ram_en, b_ram_en, b_cv_gnt} !== 3'b000)
      $display("FAIL rget_strobe got %b want 000", {a_ram_en, b_ram_en, b_cv_gnt}); else n_pass++;
    tick();
    reset = 0;
    idle();
    n_checks++; if ({a_gt_rvalid, a_frame_done, a_phase, b_cv_rvalid, b_phase} !== {2'b00, 2'b01, 1'b0, 2'b01})
      $display("FAIL rget_abort got v%b fd%b ph%b cv%b ph%b", a_gt_rvalid, a_frame_done, a_phase,
               b_cv_rvalid, b_phase); else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout after %0d checks", n_checks);
    $fatal(1);
  end

  initial begin
    tick();
    test_reset();
    test_ignore_in_load();
    test_reset_midload();
    test_load();
    test_process();
    test_get();
    test_reset_during_get();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
